// File: rtl/dasm.sv
// Registered disassembler for a small MIPS subset: 32 ASCII characters, MSB-first, space padded.
// Define DASM_NOP_ALIAS_EN to render instr 0x00000000 as "nop" instead of the sll form.
module dasm (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc,
    input  logic [31:0]  instr,
    input  logic         reg_name,
    input  logic         imm_as_dec,
    output logic [255:0] asm
);

    typedef enum logic [3:0] {
        K_ADDU, K_SUBU, K_SLL, K_JR, K_ORI, K_LUI, K_LW, K_SW,
        K_BEQ, K_J, K_JAL, K_NOP, K_UNKNOWN
    } kind_e;

    // Text under construction plus the next free character slot (32 means full).
    typedef struct packed {
        logic [255:0] text;
        logic [5:0]   pos;
    } line_t;

    localparam logic [255:0] BLANK = {32{8'h20}};

    logic [5:0]   op, funct;
    logic [4:0]   rs, rt, rd, sh;
    logic [15:0]  imm;
    logic [31:0]  pc_next, br_target, j_target;
    kind_e        kind;
    logic [255:0] next_text;

    assign op        = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign sh        = instr[10:6];
    assign funct     = instr[5:0];
    assign imm       = instr[15:0];
    assign pc_next   = pc + 32'd4;
    assign br_target = pc_next + {{14{imm[15]}}, imm, 2'b00};
    assign j_target  = {pc_next[31:28], instr[25:0], 2'b00};

    // Characters past slot 31 are silently dropped, which gives truncation for free.
    function automatic line_t put_char(line_t l, logic [7:0] c);
        line_t      r;
        logic [4:0] idx;
        r   = l;
        idx = 5'd31 - l.pos[4:0];
        if (l.pos < 6'd32) begin
            r.text[{idx, 3'b000} +: 8] = c;
            r.pos                      = l.pos + 6'd1;
        end
        return r;
    endfunction

    // s holds up to 8 characters right-justified; n is how many to emit.
    function automatic line_t put_str(line_t l, logic [63:0] s, logic [3:0] n);
        line_t       r;
        logic [63:0] w;
        r = l;
        w = s << {4'd8 - n, 3'b000};
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) r = put_char(r, w[63:56]);
            w = w << 8;
        end
        return r;
    endfunction

    function automatic line_t put_sep(line_t l);
        return put_str(l, 64'(", "), 4'd2);
    endfunction

    function automatic logic [7:0] hex_char(logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'b0000, d}) : (8'h57 + {4'b0000, d});
    endfunction

    function automatic logic [7:0] dig5(logic [4:0] d);
        return 8'h30 + {3'b000, d};
    endfunction

    // "0x" followed by the low n nibbles of v, most significant first.
    function automatic line_t put_hex(line_t l, logic [31:0] v, logic [3:0] n);
        line_t       r;
        logic [31:0] w;
        r = put_str(l, 64'("0x"), 4'd2);
        w = v << {4'd8 - n, 2'b00};
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) r = put_char(r, hex_char(w[31:28]));
            w = w << 4;
        end
        return r;
    endfunction

    // Decimal magnitude without leading zeros; a lone zero still prints "0".
    function automatic line_t put_dec(line_t l, logic [16:0] mag, logic neg);
        line_t       r;
        logic [16:0] m;
        logic [3:0]  digs [5];
        logic        started;
        r       = l;
        m       = mag;
        started = 1'b0;
        if (neg) r = put_char(r, "-");
        for (int k = 0; k < 5; k++) begin
            digs[k] = 4'(m % 17'd10);
            m       = m / 17'd10;
        end
        for (int k = 4; k >= 0; k--) begin
            if (digs[k] != 4'd0 || started || k == 0) begin
                r       = put_char(r, 8'h30 + {4'b0000, digs[k]});
                started = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic line_t put_imm(line_t l, logic [15:0] v, logic sext, logic dec);
        if (!dec) return put_hex(l, {16'h0000, v}, 4'd4);
        if (sext && v[15]) return put_dec(l, {1'b0, ~v + 16'd1}, 1'b1);
        return put_dec(l, {1'b0, v}, 1'b0);
    endfunction

    function automatic line_t put_reg(line_t l, logic [4:0] idx, logic abi);
        line_t      r;
        logic [7:0] a, b;
        r = put_char(l, "$");
        a = "a";
        b = "t";
        if (!abi) begin
            if (idx >= 5'd10) r = put_char(r, dig5(idx / 5'd10));
            r = put_char(r, dig5(idx % 5'd10));
        end else if (idx == 5'd0) begin
            r = put_str(r, 64'("zero"), 4'd4);
        end else begin
            case (idx) inside
                [5'd2:5'd3]:   begin a = "v"; b = dig5(idx - 5'd2);  end
                [5'd4:5'd7]:   begin a = "a"; b = dig5(idx - 5'd4);  end
                [5'd8:5'd15]:  begin a = "t"; b = dig5(idx - 5'd8);  end
                [5'd16:5'd23]: begin a = "s"; b = dig5(idx - 5'd16); end
                [5'd24:5'd25]: begin a = "t"; b = dig5(idx - 5'd16); end
                [5'd26:5'd27]: begin a = "k"; b = dig5(idx - 5'd26); end
                5'd28:         begin a = "g"; b = "p"; end
                5'd29:         begin a = "s"; b = "p"; end
                5'd30:         begin a = "f"; b = "p"; end
                5'd31:         begin a = "r"; b = "a"; end
                default:       begin a = "a"; b = "t"; end
            endcase
            r = put_char(r, a);
            r = put_char(r, b);
        end
        return r;
    endfunction

    // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
    always_comb begin
        kind = K_UNKNOWN;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   kind = K_ADDU;
                    6'h23:   kind = K_SUBU;
                    6'h00:   kind = K_SLL;
                    6'h08:   kind = K_JR;
                    default: kind = K_UNKNOWN;
                endcase
            end
            6'h02:   kind = K_J;
            6'h03:   kind = K_JAL;
            6'h04:   kind = K_BEQ;
            6'h0d:   kind = K_ORI;
            6'h0f:   kind = K_LUI;
            6'h23:   kind = K_LW;
            6'h2b:   kind = K_SW;
            default: kind = K_UNKNOWN;
        endcase
`ifdef DASM_NOP_ALIAS_EN
        if (instr == 32'h0000_0000) kind = K_NOP;
`else
        // The all-zero word already decodes as "sll $zero, $zero, 0".
`endif
    end

    always_comb begin
        line_t l;
        l = '{text: BLANK, pos: 6'd0};
        case (kind)
            K_ADDU, K_SUBU: begin
                l = put_str(l, (kind == K_ADDU) ? 64'("addu ") : 64'("subu "), 4'd5);
                l = put_reg(l, rd, reg_name);
                l = put_sep(l);
                l = put_reg(l, rs, reg_name);
                l = put_sep(l);
                l = put_reg(l, rt, reg_name);
            end
            K_SLL: begin
                l = put_str(l, 64'("sll "), 4'd4);
                l = put_reg(l, rd, reg_name);
                l = put_sep(l);
                l = put_reg(l, rt, reg_name);
                l = put_sep(l);
                l = put_dec(l, {12'h000, sh}, 1'b0);
            end
            K_JR: begin
                l = put_str(l, 64'("jr "), 4'd3);
                l = put_reg(l, rs, reg_name);
            end
            K_ORI: begin
                l = put_str(l, 64'("ori "), 4'd4);
                l = put_reg(l, rt, reg_name);
                l = put_sep(l);
                l = put_reg(l, rs, reg_name);
                l = put_sep(l);
                l = put_imm(l, imm, 1'b0, imm_as_dec);
            end
            K_LUI: begin
                l = put_str(l, 64'("lui "), 4'd4);
                l = put_reg(l, rt, reg_name);
                l = put_sep(l);
                l = put_imm(l, imm, 1'b0, imm_as_dec);
            end
            K_LW, K_SW: begin
                l = put_str(l, (kind == K_LW) ? 64'("lw ") : 64'("sw "), 4'd3);
                l = put_reg(l, rt, reg_name);
                l = put_sep(l);
                l = put_imm(l, imm, 1'b1, imm_as_dec);
                l = put_char(l, "(");
                l = put_reg(l, rs, reg_name);
                l = put_char(l, ")");
            end
            K_BEQ: begin
                l = put_str(l, 64'("beq "), 4'd4);
                l = put_reg(l, rs, reg_name);
                l = put_sep(l);
                l = put_reg(l, rt, reg_name);
                l = put_sep(l);
                l = put_hex(l, br_target, 4'd8);
            end
            K_J, K_JAL: begin
                l = put_str(l, (kind == K_J) ? 64'("j ") : 64'("jal "),
                            (kind == K_J) ? 4'd2 : 4'd4);
                l = put_hex(l, j_target, 4'd8);
            end
            K_NOP: l = put_str(l, 64'("nop"), 4'd3);
            default: begin
                l = put_str(l, 64'("unknown "), 4'd8);
                l = put_hex(l, instr, 4'd8);
            end
        endcase
        next_text = l.text;
    end

    // NOTE: registered state uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!reset) asm <= BLANK;
        else        asm <= next_text;
    end

endmodule

// File: tb/tb_dasm.sv
// Scoreboard bench for dasm: expected text is queued when stimulus is driven, compared one edge later.
module tb_dasm;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic         reg_name;
    logic         imm_as_dec;
    logic [255:0] asm;

    logic [255:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    dasm dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .reg_name   (reg_name),
        .imm_as_dec (imm_as_dec),
        .asm        (asm)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pad(string s);
        logic [255:0] t;
        t = {32{8'h20}};
        for (int i = 0; i < 32 && i < s.len(); i++) t[255 - 8*i -: 8] = s[i];
        return t;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
    endtask

    // Drive one sample, queue its expected text, and compare after the capturing edge.
    task automatic apply(input string tag, input logic [31:0] p, input logic [31:0] i,
                         input logic rn, input logic dec, input logic rst, input string exp);
        logic [255:0] e;
        @(negedge clk);
        pc         = p;
        instr      = i;
        reg_name   = rn;
        imm_as_dec = dec;
        reset      = rst;
        exp_q.push_back(rst ? pad(exp) : pad(""));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, asm, pad("<empty scoreboard>"));
        end else begin
            e = exp_q.pop_front();
            check(tag, asm, e);
        end
    endtask

    initial begin
        reset = 1'b0; pc = 32'h0; instr = 32'h01095021; reg_name = 1'b1; imm_as_dec = 1'b1;

        apply("reset0",     32'h0,        32'h01095021, 1, 1, 0, "");
        apply("reset1",     32'h0,        32'h01095021, 1, 1, 0, "");
        apply("addu_abi",   32'h0,        32'h01095021, 1, 1, 1, "addu $t2, $t0, $t1");
        apply("addu_num",   32'h0,        32'h01095021, 0, 1, 1, "addu $10, $8, $9");
        apply("addu_kgt",   32'h0,        32'h0399d021, 1, 0, 1, "addu $k0, $gp, $t9");
        apply("addu_kgt_n", 32'h0,        32'h0399d021, 0, 0, 1, "addu $26, $28, $25");
        apply("subu_abi",   32'h0,        32'h02328023, 1, 1, 1, "subu $s0, $s1, $s2");
        apply("subu_num",   32'h0,        32'h02328023, 0, 1, 1, "subu $16, $17, $18");
        apply("subu_fas",   32'h0,        32'h00f7f023, 1, 1, 1, "subu $fp, $a3, $s7");
        apply("sll_31",     32'h0,        32'h00084fc0, 1, 0, 1, "sll $t1, $t0, 31");
        apply("jr_abi",     32'h0,        32'h03e00008, 1, 1, 1, "jr $ra");
        apply("jr_num",     32'h0,        32'h03e00008, 0, 1, 1, "jr $31");
        apply("ori_hex",    32'h0,        32'h3409ffff, 1, 0, 1, "ori $t1, $zero, 0xffff");
        apply("ori_dec",    32'h0,        32'h3409ffff, 1, 1, 1, "ori $t1, $zero, 65535");
        apply("lui_hex",    32'h0,        32'h3c011234, 1, 0, 1, "lui $at, 0x1234");
        apply("lui_dec",    32'h0,        32'h3c011234, 1, 1, 1, "lui $at, 4660");
        apply("lw_neg_dec", 32'h0,        32'h8fa8fffc, 1, 1, 1, "lw $t0, -4($sp)");
        apply("lw_neg_hex", 32'h0,        32'h8fa8fffc, 1, 0, 1, "lw $t0, 0xfffc($sp)");
        apply("lw_zero",    32'h0,        32'h8fa80000, 1, 1, 1, "lw $t0, 0($sp)");
        apply("sw_min_dec", 32'h0,        32'hafbf8000, 1, 1, 1, "sw $ra, -32768($sp)");
        apply("sw_min_num", 32'h0,        32'hafbf8000, 0, 1, 1, "sw $31, -32768($29)");
        apply("sw_min_hex", 32'h0,        32'hafbf8000, 1, 0, 1, "sw $ra, 0x8000($sp)");
        apply("sw_pos",     32'h0,        32'hafbf0010, 1, 1, 1, "sw $ra, 16($sp)");
        apply("beq_back",   32'h00003000, 32'h1000ffff, 1, 0, 1, "beq $zero, $zero, 0x00003000");
        apply("beq_wrap",   32'hfffffffc, 32'h10000000, 1, 1, 1, "beq $zero, $zero, 0x00000000");
        apply("jal",        32'h00003000, 32'h0c000c00, 1, 1, 1, "jal 0x00003000");
        apply("j_region",   32'h80000000, 32'h0bffffff, 1, 0, 1, "j 0x8ffffffc");
`ifdef DASM_NOP_ALIAS_EN
        apply("nop_abi",    32'h0,        32'h00000000, 1, 1, 1, "nop");
        apply("nop_num",    32'h0,        32'h00000000, 0, 1, 1, "nop");
`else
        apply("nop_abi",    32'h0,        32'h00000000, 1, 1, 1, "sll $zero, $zero, 0");
        apply("nop_num",    32'h0,        32'h00000000, 0, 1, 1, "sll $0, $0, 0");
`endif
        apply("unk_op",     32'h0,        32'hfc000000, 1, 1, 1, "unknown 0xfc000000");
        apply("unk_funct",  32'h0,        32'h0000000c, 1, 1, 1, "unknown 0x0000000c");
        apply("mid_reset",  32'h0,        32'h01095021, 1, 1, 0, "");
        apply("after_rst",  32'h0,        32'h01095021, 1, 1, 1, "addu $t2, $t0, $t1");

        for (int k = 0; k < 8; k++) begin
            logic [4:0] r;
            string      s;
            r = 5'($urandom_range(0, 31));
            s = $sformatf("addu $%0d, $%0d, $%0d", r, r, r);
            apply("addu_rand", 32'h0, {6'h00, r, r, r, 5'h00, 6'h21}, 0, 1, 1, s);
        end

        if (exp_q.size() != 0) check("scoreboard_drain", 256'(exp_q.size()), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
